// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store memory controller.
package lsu_pkg;

  // funct3 width/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller sequencing: wait for an op, talk to memory, report result
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/data and fault detection on the request
// side, extraction and sign/zero extension of the read word on the response side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  req_lane_i,
  input  logic [2:0]  req_funct3_i,
  input  logic        req_is_store_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  rsp_lane_i,
  input  logic [2:0]  rsp_funct3_i,
  input  logic [31:0] rsp_rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        err_o,
  output logic [31:0] load_data_o
);

  logic [31:0] rdata_shifted;

  // Bring the addressed byte/half down to bit 0 before extension
  assign rdata_shifted = rsp_rdata_i >> {rsp_lane_i, 3'b000};

  // Request side: lane strobes, replicated store data, misalign/illegal code
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = '0;
    err_o   = 1'b0;
    case (req_funct3_i)
      F3_B: begin
        wstrb_o = 4'b0001 << req_lane_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      F3_H: begin
        wstrb_o = req_lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{req_wdata_i[15:0]}};
        err_o   = req_lane_i[0];
      end
      F3_W: begin
        wstrb_o = 4'b1111;
        wdata_o = req_wdata_i;
        err_o   = |req_lane_i;
      end
      // Unsigned variants exist only for loads
      F3_BU:   err_o = req_is_store_i;
      F3_HU:   err_o = req_is_store_i | req_lane_i[0];
      default: err_o = 1'b1;
    endcase
    if (!req_is_store_i) begin
      wstrb_o = 4'b0000;
    end
  end

  // Response side: sign- or zero-extend the selected field
  always_comb begin
    load_data_o = '0;
    case (rsp_funct3_i)
      F3_B:    load_data_o = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3_H:    load_data_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3_W:    load_data_o = rsp_rdata_i;
      F3_BU:   load_data_o = {24'h000000, rdata_shifted[7:0]};
      F3_HU:   load_data_o = {16'h0000, rdata_shifted[15:0]};
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: effective-address adder, single-outstanding
// request/acknowledge sequencing to data memory, registered results.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_imm,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              fault
);

  lsu_state_t        state_q;
  logic              ready_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       mem_wdata_q;
  logic [1:0]        lane_q;
  logic [2:0]        funct3_q;
  logic              done_q;
  logic              fault_q;
  logic [31:0]       load_data_q;

  logic [31:0] ea_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic        err_d;
  logic [31:0] load_ext_d;

  // Effective address wraps modulo 2^32
  assign ea_d = req_base + req_imm;

  lsu_align u_align (
    .req_lane_i     (ea_d[1:0]),
    .req_funct3_i   (req_funct3),
    .req_is_store_i (req_is_store),
    .req_wdata_i    (req_wdata),
    .rsp_lane_i     (lane_q),
    .rsp_funct3_i   (funct3_q),
    .rsp_rdata_i    (mem_rdata),
    .wstrb_o        (wstrb_d),
    .wdata_o        (wdata_d),
    .err_o          (err_d),
    .load_data_o    (load_ext_d)
  );

  // Sequencer and all registered outputs; ack outside ACCESS has no effect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      lane_q      <= 2'b00;
      funct3_q    <= 3'b000;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            if (err_d) begin
              // Faults skip memory entirely and report next cycle
              state_q <= RESP;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q     <= ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_is_store;
              mem_addr_q  <= {ea_d[ADDR_W-1:2], 2'b00};
              mem_wstrb_q <= wstrb_d;
              mem_wdata_q <= wdata_d;
              lane_q      <= ea_d[1:0];
              funct3_q    <= req_funct3;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
            done_q      <= 1'b1;
            load_data_q <= mem_we_q ? 32'h0 : load_ext_d;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          done_q      <= 1'b0;
          fault_q     <= 1'b0;
          load_data_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus randomized ops against a
// byte-level reference model; one line printed per transaction.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] load_data;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_base     (req_base),
    .req_imm      (req_imm),
    .req_wdata    (req_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .done         (done),
    .load_data    (load_data),
    .fault        (fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: access size in bytes, fault rule, lane arithmetic, extension
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] wd,
                        input int dly, input logic [31:0] rd);
    logic [31:0] ea, e_addr, e_strb, e_wdata, e_load;
    longint      v, half_range;
    int          size, lane;
    bit          legal, flt;
    ea     = base + imm;
    legal  = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size   = 1 << f3[1:0];
    lane   = int'(ea % 4);
    flt    = !legal || ((ea % size) != 0);
    e_addr = ea - (ea % 4);
    e_strb = st ? (((32'd1 << size) - 1) << lane) : 32'd0;
    if (size == 1)      e_wdata = {24'h0, wd[7:0]} * 32'h01010101;
    else if (size == 2) e_wdata = {16'h0, wd[15:0]} * 32'h00010001;
    else                e_wdata = wd;
    v = longint'(rd) / (longint'(1) << (8 * lane));
    v = v % (longint'(1) << (8 * size));
    half_range = longint'(1) << (8 * size - 1);
    if (!f3[2] && size < 4 && v >= half_range) v = v - 2 * half_range;
    e_load = (st || flt) ? 32'd0 : v[31:0];

    @(negedge clk);
    req_is_store = st;
    req_funct3   = f3;
    req_base     = base;
    req_imm      = imm;
    req_wdata    = wd;
    req_valid    = 1'b1;
    check_eq("ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_base  = $urandom;
    req_wdata = $urandom;
    if (flt) begin
      check_eq("flt_done", {31'd0, done}, 32'd1);
      check_eq("flt_fault", {31'd0, fault}, 32'd1);
      check_eq("flt_ldata", load_data, 32'd0);
      check_eq("flt_noreq", {31'd0, mem_req}, 32'd0);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check_eq("flt_done_end", {31'd0, done}, 32'd0);
      check_eq("flt_noreq2", {31'd0, mem_req}, 32'd0);
    end else begin
      for (int k = 0; k <= dly; k++) begin
        check_eq("acc_req", {31'd0, mem_req}, 32'd1);
        check_eq("acc_addr", mem_addr, e_addr);
        check_eq("acc_we", {31'd0, mem_we}, {31'd0, st});
        check_eq("acc_strb", {28'd0, mem_wstrb}, e_strb);
        if (st) check_eq("acc_wdata", mem_wdata, e_wdata);
        check_eq("acc_busy", {31'd0, req_ready}, 32'd0);
        check_eq("acc_nodone", {31'd0, done}, 32'd0);
        mem_ack   = (k == dly);
        mem_rdata = (k == dly) ? rd : $urandom;
        @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      check_eq("rsp_done", {31'd0, done}, 32'd1);
      check_eq("rsp_fault", {31'd0, fault}, 32'd0);
      check_eq("rsp_ldata", load_data, e_load);
      check_eq("rsp_noreq", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      check_eq("rsp_done_end", {31'd0, done}, 32'd0);
    end
    check_eq("ready_back", {31'd0, req_ready}, 32'd1);
    $display("op st=%0d f3=%0d ea=0x%08h dly=%0d fault=%0d load=0x%08h", st, f3, ea, dly, flt, e_load);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_base = '0; req_imm = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_strb", {28'd0, mem_wstrb}, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_ldata", load_data, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);

    // Directed cases
    run_op(1'b0, 3'b010, 32'h100, 32'd4, 32'h0, 0, 32'hDEADBEEF);
    run_op(1'b0, 3'b000, 32'h100, 32'd3, 32'h0, 0, 32'h80112233);
    run_op(1'b0, 3'b100, 32'h100, 32'd3, 32'h0, 1, 32'h80112233);
    run_op(1'b0, 3'b101, 32'h100, 32'd2, 32'h0, 0, 32'h80112233);
    run_op(1'b1, 3'b001, 32'h200, 32'd2, 32'h1234ABCD, 0, 32'h0);
    run_op(1'b0, 3'b010, 32'h100, 32'd2, 32'h0, 0, 32'h0);
    run_op(1'b0, 3'b011, 32'h100, 32'd0, 32'h0, 0, 32'h0);
    run_op(1'b1, 3'b100, 32'h100, 32'd0, 32'h55, 0, 32'h0);
    run_op(1'b0, 3'b010, 32'hFFFFFFFC, 32'd8, 32'h0, 5, 32'hCAFEF00D);
    run_op(1'b1, 3'b000, 32'h301, 32'd0, 32'h000000A5, 2, 32'h0);

    // Reset during a stalled access
    @(negedge clk);
    req_is_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h400; req_imm = 32'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rma_req1", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    check_eq("rma_req2", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rma_noreq", {31'd0, mem_req}, 32'd0);
    check_eq("rma_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rma_nodone", {31'd0, done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      check_eq("rma_quiet", {31'd0, done | mem_req}, 32'd0);
    end
    mem_ack = 1'b0;
    $display("op reset-mid-access abandoned");

    // Randomized ops
    for (int n = 0; n < 200; n++) begin
      logic [31:0] b, im;
      b  = $urandom;
      im = $urandom_range(0, 1) ? $urandom : {{20{1'b0}}, 12'($urandom)};
      run_op(1'($urandom), 3'($urandom), b, im, $urandom, int'($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
